// File: rtl/ipml_fifo_pkt_reader.sv
// Packet reader: pulls length-prefixed packets out of a FIFO read port and
// replays the payload as a valid/ready stream with sop/eop markers. The
// header word is consumed internally and never reaches the stream.
module ipml_fifo_pkt_reader #(
    parameter int c_DATA_WIDTH     = 32,
    parameter int c_RD_DEPTH_WIDTH = 9,
    parameter int c_LEN_WIDTH      = 16
) (
    input  logic                      rclk,
    input  logic                      rrst,
    input  logic                      rempty,
    input  logic [c_RD_DEPTH_WIDTH:0] rd_water_level,
    output logic                      r_en,
    input  logic [c_DATA_WIDTH-1:0]   rd_data,
    output logic [c_DATA_WIDTH-1:0]   m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic [15:0]               pkt_cnt,
    output logic                      len_err,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_LEN_WIDTH-1:0]   r_len;
    logic [c_LEN_WIDTH-1:0]   r_iss_cnt;
    logic                     r_len_err;
    logic [15:0]              r_pkt_cnt;

    // One payload read can be outstanding: its data lands next cycle
    logic                     r_inflight;
    logic                     r_infl_sop;
    logic                     r_infl_eop;

    // 3-entry output buffer, ring addressed 0..2
    logic [c_DATA_WIDTH-1:0]  r_buf_data [0:2];
    logic [2:0]               r_buf_sop;
    logic [2:0]               r_buf_eop;
    logic [1:0]               r_wr_ptr;
    logic [1:0]               r_rd_ptr;
    logic [1:0]               r_buf_cnt;

    logic                     w_room;
    logic                     w_rd_hdr;
    logic                     w_rd_pld;
    logic                     w_valid;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_unused_level;

    // Fill level is informational only
    assign w_unused_level = ^rd_water_level;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue only if every word already committed (buffered + returning)
    // plus this one still fits in the buffer, assuming no pops happen.
    assign w_room   = ({1'b0, r_buf_cnt} + {2'b00, r_inflight}) <= 3'd2;
    assign w_rd_hdr = (r_state == IDLE) && !rempty;
    assign w_rd_pld = (r_state == PLD) && !rempty && w_room &&
                      (r_iss_cnt != '0);

    // Read enable depends only on local state and rempty, never m_ready;
    // reset gates it so no read slips out while rrst is held.
    assign r_en     = !rrst && (w_rd_hdr || w_rd_pld);

    assign w_valid  = (r_buf_cnt != 2'd0);
    assign w_push   = r_inflight;
    assign w_pop    = w_valid && m_ready;

    assign m_valid  = w_valid;
    assign m_data   = w_valid ? r_buf_data[r_rd_ptr] : '0;
    assign m_sop    = w_valid && r_buf_sop[r_rd_ptr];
    assign m_eop    = w_valid && r_buf_eop[r_rd_ptr];
    assign pkt_cnt  = r_pkt_cnt;
    assign len_err  = r_len_err;
    assign busy     = (r_state != IDLE) || w_valid;

    // Packet sequencing: header fetch, length decode, payload issue
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_iss_cnt <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rd_hdr)
                        r_state <= HDR;
                end
                HDR: begin
                    r_len <= rd_data[c_LEN_WIDTH-1:0];
                    if (rd_data[c_LEN_WIDTH-1:0] == '0) begin
                        r_len_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_iss_cnt <= rd_data[c_LEN_WIDTH-1:0];
                        r_state   <= PLD;
                    end
                end
                PLD: begin
                    if (w_rd_pld) begin
                        r_iss_cnt <= r_iss_cnt - c_LEN_WIDTH'(1);
                        if (r_iss_cnt == c_LEN_WIDTH'(1))
                            r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag each payload read so sop/eop arrive alongside its data
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_inflight <= 1'b0;
            r_infl_sop <= 1'b0;
            r_infl_eop <= 1'b0;
        end else begin
            r_inflight <= w_rd_pld;
            r_infl_sop <= w_rd_pld && (r_iss_cnt == r_len);
            r_infl_eop <= w_rd_pld && (r_iss_cnt == c_LEN_WIDTH'(1));
        end
    end

    // Output buffer: write returned payload, pop on handshake
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < 3; i++)
                r_buf_data[i] <= '0;
            r_buf_sop <= '0;
            r_buf_eop <= '0;
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_buf_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf_data[r_wr_ptr] <= rd_data;
                r_buf_sop[r_wr_ptr]  <= r_infl_sop;
                r_buf_eop[r_wr_ptr]  <= r_infl_eop;
                r_wr_ptr             <= f_next(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase
        end
    end

    // Completed packets counted as their last word leaves the stream
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst)
            r_pkt_cnt <= 16'd0;
        else if (w_pop && r_buf_eop[r_rd_ptr])
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end

endmodule

// File: tb/tb_ipml_fifo_pkt_reader.sv
// Bench for ipml_fifo_pkt_reader: queue-based FIFO source, expected-word
// scoreboard built from the packet format, directed and random phases.
module tb_ipml_fifo_pkt_reader;

    localparam int DW  = 32;
    localparam int DWL = 9;
    localparam int LW  = 16;

    logic          rclk;
    logic          rrst;
    logic          rempty;
    logic [DWL:0]  rd_water_level;
    logic          r_en;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_sop;
    logic          m_eop;
    logic [15:0]   pkt_cnt;
    logic          len_err;
    logic          busy;

    ipml_fifo_pkt_reader #(
        .c_DATA_WIDTH     (DW),
        .c_RD_DEPTH_WIDTH (DWL),
        .c_LEN_WIDTH      (LW)
    ) dut (
        .rclk           (rclk),
        .rrst           (rrst),
        .rempty         (rempty),
        .rd_water_level (rd_water_level),
        .r_en           (r_en),
        .rd_data        (rd_data),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_sop          (m_sop),
        .m_eop          (m_eop),
        .pkt_cnt        (pkt_cnt),
        .len_err        (len_err),
        .busy           (busy)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo [$];
    logic [33:0]   exp_q [$];

    int  rdy_mode   = 0;   // 0 always ready, 1 never ready, 2 random
    int  stall_mode = 0;   // 0 none, 1 toggle, 2 random
    bit  tog        = 1'b0;
    int  cyc        = 0;
    int  ren_cnt    = 0;
    int  lerr_cnt   = 0;
    int  viol       = 0;
    logic [31:0] en_mask  = '0;
    logic [31:0] vld_mask = '0;
    bit          prev_hold = 1'b0;
    logic [33:0] prev_out  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int len);
        logic [DW-1:0] hdr;
        logic [DW-1:0] w;
        hdr = $urandom;
        hdr[LW-1:0] = LW'(len);
        fifo.push_back(hdr);
        for (int k = 0; k < len; k++) begin
            w = $urandom;
            fifo.push_back(w);
            exp_q.push_back({w, k == 0, k == len - 1});
        end
    endtask

    // One clock: drive m_ready, sample before the edge, then act as the FIFO
    task automatic tick();
        logic s_ren;
        bit   stall;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge rclk);
        s_ren = r_en;
        if (r_en && rempty) viol++;
        if (len_err) lerr_cnt++;
        if (r_en) ren_cnt++;
        if (cyc < 32) begin
            en_mask[cyc]  = r_en;
            vld_mask[cyc] = m_valid;
        end
        cyc++;
        if (prev_hold)
            chk("hold", 64'({m_valid, m_data, m_sop, m_eop}), 64'({1'b1, prev_out}));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0)
                chk("extra_word", 64'({m_data, m_sop, m_eop}), 64'hDEAD);
            else
                chk("word", 64'({m_data, m_sop, m_eop}), 64'(exp_q.pop_front()));
        end
        prev_hold = m_valid && !m_ready;
        prev_out  = {m_data, m_sop, m_eop};
        @(posedge rclk);
        #1;
        if (s_ren && fifo.size() > 0) rd_data = fifo.pop_front();
        else                          rd_data = $urandom;
        case (stall_mode)
            1:       stall = tog;
            2:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
        endcase
        tog = !tog;
        rempty = (fifo.size() == 0) || stall;
        rd_water_level = (DWL+1)'(fifo.size());
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(fifo.size() == 0 && exp_q.size() == 0 && !busy && !r_en) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(fifo.size() == 0 && exp_q.size() == 0 && !busy), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_r_en"},    64'(r_en),    64'd0);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_m_sop"},   64'(m_sop),   64'd0);
        chk({tag, "_m_eop"},   64'(m_eop),   64'd0);
        chk({tag, "_m_data"},  64'(m_data),  64'd0);
        chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        chk({tag, "_len_err"}, 64'(len_err), 64'd0);
        chk({tag, "_busy"},    64'(busy),    64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a non-empty flag: read enable must stay low
        rrst = 1'b1; rempty = 1'b0; m_ready = 1'b0; rd_data = '0; rd_water_level = '0;
        repeat (3) @(posedge rclk);
        #1;
        chk_reset_outputs("reset");

        // Three-word packet, latency and ordering
        push_pkt(3);
        rempty = 1'b0;
        rrst = 1'b0;
        cyc = 0; en_mask = '0; vld_mask = '0;
        drain(50);
        chk("len3_ren_cycles", 64'(en_mask[7:0]), 64'h1D);
        chk("len3_vld_cycles", 64'(vld_mask[7:0]), 64'h70);
        chk("len3_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Zero-length header then a one-word packet
        lerr_cnt = 0;
        push_pkt(0);
        push_pkt(1);
        drain(50);
        chk("zero_len_err", 64'(lerr_cnt), 64'd1);
        chk("zero_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // Backpressure: at most 3 payload reads, head held
        rdy_mode = 1; ren_cnt = 0;
        push_pkt(8);
        repeat (20) tick();
        chk("bp_reads", 64'(ren_cnt), 64'd4);
        chk("bp_valid", 64'(m_valid), 64'd1);
        chk("bp_sop", 64'(m_sop), 64'd1);
        rdy_mode = 0;
        drain(100);
        chk("bp_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Toggling empty flag during a len-5 packet
        stall_mode = 1; viol = 0;
        push_pkt(5);
        drain(100);
        chk("toggle_no_read_when_empty", 64'(viol), 64'd0);
        chk("toggle_pkt_cnt", 64'(pkt_cnt), 64'd4);
        stall_mode = 0;

        // Reset during the second payload word of a len-4 packet
        ren_cnt = 0;
        push_pkt(4);
        for (int n = 0; n < 30 && ren_cnt < 3; n++) tick();
        chk("mid_reset_reached", 64'(ren_cnt), 64'd3);
        rrst = 1'b1;
        #1;
        chk_reset_outputs("mid_reset");
        fifo.delete();
        exp_q.delete();
        prev_hold = 1'b0;
        repeat (2) tick();
        rrst = 1'b0;
        push_pkt(3);
        drain(50);
        chk("post_reset_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Random back-to-back packets with random backpressure and stalls
        rdy_mode = 2; stall_mode = 2; viol = 0; lerr_cnt = 0;
        for (int p = 0; p < 30; p++) push_pkt(int'($urandom_range(1, 64)));
        drain(20000);
        chk("rand_pkt_cnt", 64'(pkt_cnt), 64'd31);
        chk("rand_no_read_when_empty", 64'(viol), 64'd0);
        chk("rand_no_len_err", 64'(lerr_cnt), 64'd0);

        // Packet counter wrap
        rdy_mode = 0; stall_mode = 0;
        force dut.r_pkt_cnt = 16'hFFFE;
        @(negedge rclk);
        release dut.r_pkt_cnt;
        @(posedge rclk);
        #1;
        push_pkt(1);
        drain(50);
        chk("wrap_ffff", 64'(pkt_cnt), 64'hFFFF);
        push_pkt(1);
        drain(50);
        chk("wrap_zero", 64'(pkt_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
